cpu_rd_dbuf: RTL and testbench

//  CPU read data return buffer for the VGA memory read path, downstream of the CPU read FSM.

---
 rtl/cpu_rd_dbuf_if.sv | 28 ++
 rtl/cpu_rd_dbuf.sv | 142 ++++++++++++++
 tb/tb_cpu_rd_dbuf.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_rd_dbuf_if.sv
// cpu_rd_dbuf_if: host/memory handshake bundle for the CPU read data return buffer.
// master = read FSM / memory / host side, slave = the buffer itself.
interface cpu_rd_dbuf_if #(
   parameter int DW = 32
);
   logic          rd_start;
   logic [1:0]    rd_len;
   logic          t_data_ready_n;
   logic [DW-1:0] m_t_mem_data_in;
   logic          h_rd_ack;
   logic [DW-1:0] h_rd_data;
   logic          h_rd_valid;
   logic          g_cpu_cycle_done;
   logic          g_cpu_data_done;
   logic          busy;
   logic          ovf_err;
   logic [DW-1:0] g_latch_data;

   modport master (
      output rd_start, rd_len, t_data_ready_n, m_t_mem_data_in, h_rd_ack,
      input  h_rd_data, h_rd_valid, g_cpu_cycle_done, g_cpu_data_done, busy, ovf_err, g_latch_data
   );

   modport slave (
      input  rd_start, rd_len, t_data_ready_n, m_t_mem_data_in, h_rd_ack,
      output h_rd_data, h_rd_valid, g_cpu_cycle_done, g_cpu_data_done, busy, ovf_err, g_latch_data
   );
endinterface

// File: rtl/cpu_rd_dbuf.sv
// cpu_rd_dbuf: CPU read data return buffer for the VGA memory read path.
// Captures memory read beats into a small FIFO, signals burst capture / drain
// completion to the read FSM and hands data to the host with valid/ack.
// Optional feature macro: CPU_RD_LATCH_EN (keeps the last accepted beat in
// g_latch_data; when undefined g_latch_data is tied to 0).
module cpu_rd_dbuf #(
   parameter int DEPTH = 4,   // power of two, >= 2, >= max burst
   parameter int DW    = 32
) (
   input logic          mem_clk,
   input logic          hreset,
   cpu_rd_dbuf_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [1:0]            len_q, len_d;
   logic [1:0]            beat_cnt_q, beat_cnt_d;
   logic [1:0]            pop_cnt_q, pop_cnt_d;
   logic                  cdone_q, cdone_d;
   logic                  ddone_q, ddone_d;
   logic                  ovf_q, ovf_d;
   logic [AW:0]           wr_ptr_q, wr_ptr_d;
   logic [AW:0]           rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0][DW-1:0] mem_q;

   logic beat, pop, empty, full, wr_en, last_beat, last_pop;

   assign beat  = ~bus.t_data_ready_n;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = bus.h_rd_ack & ~empty;
   // A pop frees the slot being written, so a beat while full still lands if popped together.
   assign wr_en     = (state_q == S_COLLECT) & beat & (~full | pop);
   assign last_beat = wr_en & (beat_cnt_q == len_q);
   assign last_pop  = pop & (pop_cnt_q == len_q) & (state_q != S_IDLE);

   // Next-state logic: burst FSM, beat/pop counters, done pulses and overflow flag.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      pop_cnt_d  = pop_cnt_q;
      cdone_d    = 1'b0;
      ddone_d    = 1'b0;
      ovf_d      = ovf_q;
      wr_ptr_d   = wr_ptr_q + (AW+1)'(wr_en);
      rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
      case (state_q)
         S_IDLE: begin
            if (beat) ovf_d = 1'b1;
            if (bus.rd_start) begin
               len_d      = bus.rd_len;
               beat_cnt_d = '0;
               pop_cnt_d  = '0;
               state_d    = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (beat && !wr_en) ovf_d = 1'b1;
            if (wr_en) beat_cnt_d = beat_cnt_q + 2'd1;
            if (pop)   pop_cnt_d  = pop_cnt_q + 2'd1;
            if (last_pop) ddone_d = 1'b1;
            if (last_beat) begin
               cdone_d = 1'b1;
               state_d = last_pop ? S_IDLE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (beat) ovf_d = 1'b1;
            if (pop)  pop_cnt_d = pop_cnt_q + 2'd1;
            if (last_pop) begin
               ddone_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers; reset discards any burst in flight without done pulses.
   always_ff @(posedge mem_clk or posedge hreset) begin
      if (hreset) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         beat_cnt_q <= '0;
         pop_cnt_q  <= '0;
         cdone_q    <= 1'b0;
         ddone_q    <= 1'b0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         beat_cnt_q <= beat_cnt_d;
         pop_cnt_q  <= pop_cnt_d;
         cdone_q    <= cdone_d;
         ddone_q    <= ddone_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // FIFO storage; cleared on reset so h_rd_data reads 0 out of reset.
   always_ff @(posedge mem_clk or posedge hreset) begin
      if (hreset) begin
         mem_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (wr_en && (wr_ptr_q[AW-1:0] == AW'(i)))
               mem_q[i] <= bus.m_t_mem_data_in;
      end
   end

   assign bus.h_rd_data        = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.h_rd_valid       = ~empty;
   assign bus.g_cpu_cycle_done = cdone_q;
   assign bus.g_cpu_data_done  = ddone_q;
   assign bus.busy             = (state_q != S_IDLE);
   assign bus.ovf_err          = ovf_q;

`ifdef CPU_RD_LATCH_EN
   logic [DW-1:0] latch_q;

   // VGA read latch: follows accepted beats only, holds between bursts.
   always_ff @(posedge mem_clk or posedge hreset) begin
      if (hreset)     latch_q <= '0;
      else if (wr_en) latch_q <= bus.m_t_mem_data_in;
   end

   assign bus.g_latch_data = latch_q;
`else
   assign bus.g_latch_data = '0;
`endif

endmodule

// File: tb/tb_cpu_rd_dbuf.sv
// Bench for cpu_rd_dbuf: directed vector table, hand-written reset/latch
// sequences and random traffic checked against a queue-based reference model.
module tb_cpu_rd_dbuf;
   localparam int DEPTH = 4;
   localparam int DW    = 32;

   logic mem_clk = 1'b0;
   logic hreset  = 1'b1;
   always #5 mem_clk = ~mem_clk;

   cpu_rd_dbuf_if #(.DW(DW)) bus();

   cpu_rd_dbuf #(.DEPTH(DEPTH), .DW(DW)) dut (
      .mem_clk (mem_clk),
      .hreset  (hreset),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_phase;      // 0 idle, 1 collecting, 2 draining
   int          m_need;       // beats in current burst
   int          m_beats, m_pops;
   logic [31:0] m_q[$];
   bit          m_ovf, m_cd, m_dd;
   logic [31:0] m_latch;

   function automatic void m_reset();
      m_phase = 0; m_need = 0; m_beats = 0; m_pops = 0;
      m_q.delete(); m_ovf = 0; m_cd = 0; m_dd = 0; m_latch = '0;
   endfunction

   function automatic void m_step();
      bit beat, pop, was_full, acc;
      beat     = !bus.t_data_ready_n;
      pop      = bus.h_rd_ack && (m_q.size() > 0);
      was_full = (m_q.size() == DEPTH);
      acc      = 0;
      m_cd = 0; m_dd = 0;
      case (m_phase)
         0: begin
            if (beat) m_ovf = 1;
            if (bus.rd_start) begin
               m_need = int'(bus.rd_len) + 1; m_beats = 0; m_pops = 0; m_phase = 1;
            end
         end
         1: begin
            if (beat) begin
               if (!was_full || pop) acc = 1; else m_ovf = 1;
            end
            if (pop) begin m_pops++; if (m_pops == m_need) m_dd = 1; end
            if (acc) begin m_beats++; if (m_beats == m_need) m_cd = 1; end
            if (m_cd) m_phase = m_dd ? 0 : 2;
         end
         default: begin
            if (beat) m_ovf = 1;
            if (pop) begin
               m_pops++;
               if (m_pops == m_need) begin m_dd = 1; m_phase = 0; end
            end
         end
      endcase
      if (pop) void'(m_q.pop_front());
      if (acc) begin m_q.push_back(bus.m_t_mem_data_in); m_latch = bus.m_t_mem_data_in; end
   endfunction

   task automatic m_check();
      chk("model.valid", bus.h_rd_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("model.data", bus.h_rd_data, m_q[0]);
      chk("model.cdone", bus.g_cpu_cycle_done, m_cd);
      chk("model.ddone", bus.g_cpu_data_done, m_dd);
      chk("model.busy",  bus.busy, m_phase != 0);
      chk("model.ovf",   bus.ovf_err, m_ovf);
`ifdef CPU_RD_LATCH_EN
      chk("model.latch", bus.g_latch_data, m_latch);
`else
      chk("model.latch", bus.g_latch_data, 32'h0);
`endif
   endtask

   // Drive one cycle of inputs, advance the model at the edge, compare after it.
   task automatic cyc(input bit st, input logic [1:0] ln, input bit rn,
                      input logic [31:0] d, input bit ack);
      bus.rd_start = st; bus.rd_len = ln; bus.t_data_ready_n = rn;
      bus.m_t_mem_data_in = d; bus.h_rd_ack = ack;
      @(posedge mem_clk);
      m_step();
      #1;
      m_check();
   endtask

   // Asynchronous reset pulse between edges; outputs must clear at once.
   task automatic do_reset(input string nm);
      bus.rd_start = 0; bus.rd_len = 0; bus.t_data_ready_n = 1;
      bus.m_t_mem_data_in = '0; bus.h_rd_ack = 0;
      hreset = 1;
      #2;
      m_reset();
      chk({nm, ".valid"}, bus.h_rd_valid, 0);
      chk({nm, ".data"},  bus.h_rd_data, 0);
      chk({nm, ".cdone"}, bus.g_cpu_cycle_done, 0);
      chk({nm, ".ddone"}, bus.g_cpu_data_done, 0);
      chk({nm, ".busy"},  bus.busy, 0);
      chk({nm, ".ovf"},   bus.ovf_err, 0);
      chk({nm, ".latch"}, bus.g_latch_data, 0);
      hreset = 0;
   endtask

   typedef struct {
      bit st; logic [1:0] ln; bit rn; logic [31:0] d; bit ack;
      bit ev; logic [31:0] ed; bit ecd; bit edd; bit ebusy; bit eovf;
   } vec_t;

   vec_t tbl[24];

   initial begin
      // st ln rn d ack | valid data cdone ddone busy ovf
      tbl[0]  = '{1, 0, 1, 32'h0,         0, 0, 32'h0,         0, 0, 1, 0};
      tbl[1]  = '{0, 0, 0, 32'hA5A5_0001, 0, 1, 32'hA5A5_0001, 1, 0, 1, 0};
      tbl[2]  = '{0, 0, 1, 32'h0,         1, 0, 32'h0,         0, 1, 0, 0};
      tbl[3]  = '{0, 0, 1, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0};
      tbl[4]  = '{1, 3, 1, 32'h0,         0, 0, 32'h0,         0, 0, 1, 0};
      tbl[5]  = '{0, 0, 0, 32'h1,         0, 1, 32'h1,         0, 0, 1, 0};
      tbl[6]  = '{0, 0, 0, 32'h2,         0, 1, 32'h1,         0, 0, 1, 0};
      tbl[7]  = '{0, 0, 0, 32'h3,         0, 1, 32'h1,         0, 0, 1, 0};
      tbl[8]  = '{0, 0, 0, 32'h4,         0, 1, 32'h1,         1, 0, 1, 0};
      tbl[9]  = '{0, 0, 1, 32'h0,         1, 1, 32'h2,         0, 0, 1, 0};
      tbl[10] = '{0, 0, 1, 32'h0,         1, 1, 32'h3,         0, 0, 1, 0};
      tbl[11] = '{0, 0, 1, 32'h0,         1, 1, 32'h4,         0, 0, 1, 0};
      tbl[12] = '{0, 0, 1, 32'h0,         1, 0, 32'h0,         0, 1, 0, 0};
      tbl[13] = '{1, 1, 1, 32'h0,         0, 0, 32'h0,         0, 0, 1, 0};
      tbl[14] = '{0, 0, 0, 32'h33,        0, 1, 32'h33,        0, 0, 1, 0};
      tbl[15] = '{0, 0, 1, 32'h0,         1, 0, 32'h0,         0, 0, 1, 0};
      tbl[16] = '{0, 0, 0, 32'h44,        0, 1, 32'h44,        1, 0, 1, 0};
      tbl[17] = '{0, 0, 1, 32'h0,         1, 0, 32'h0,         0, 1, 0, 0};
      tbl[18] = '{1, 0, 1, 32'h0,         0, 0, 32'h0,         0, 0, 1, 0};
      tbl[19] = '{0, 0, 0, 32'h55,        0, 1, 32'h55,        1, 0, 1, 0};
      tbl[20] = '{0, 0, 0, 32'h66,        0, 1, 32'h55,        0, 0, 1, 1};
      tbl[21] = '{0, 0, 1, 32'h0,         1, 0, 32'h0,         0, 1, 0, 1};
      tbl[22] = '{0, 0, 0, 32'h77,        0, 0, 32'h0,         0, 0, 0, 1};
      tbl[23] = '{0, 0, 1, 32'h0,         0, 0, 32'h0,         0, 0, 0, 1};

      bus.rd_start = 0; bus.rd_len = 0; bus.t_data_ready_n = 1;
      bus.m_t_mem_data_in = '0; bus.h_rd_ack = 0;
      @(posedge mem_clk);
      #1;
      do_reset("reset");

      // directed table: single beat, 4-beat full burst, early drain, overflow
      for (int i = 0; i < 24; i++) begin
         cyc(tbl[i].st, tbl[i].ln, tbl[i].rn, tbl[i].d, tbl[i].ack);
         chk($sformatf("vec%0d.valid", i), bus.h_rd_valid, tbl[i].ev);
         if (tbl[i].ev) chk($sformatf("vec%0d.data", i), bus.h_rd_data, tbl[i].ed);
         chk($sformatf("vec%0d.cdone", i), bus.g_cpu_cycle_done, tbl[i].ecd);
         chk($sformatf("vec%0d.ddone", i), bus.g_cpu_data_done, tbl[i].edd);
         chk($sformatf("vec%0d.busy", i),  bus.busy, tbl[i].ebusy);
         chk($sformatf("vec%0d.ovf", i),   bus.ovf_err, tbl[i].eovf);
      end

      // reset in the middle of a 4-beat burst, then a clean 1-beat burst
      do_reset("rst2");
      cyc(1, 3, 1, 0, 0);
      cyc(0, 0, 0, 32'hB1, 0);
      cyc(0, 0, 0, 32'hB2, 0);
      do_reset("midburst");
      cyc(0, 0, 1, 0, 1);
      chk("t5.idle_cdone", bus.g_cpu_cycle_done, 0);
      chk("t5.idle_ddone", bus.g_cpu_data_done, 0);
      cyc(1, 0, 1, 0, 0);
      cyc(0, 0, 0, 32'hC1, 0);
      chk("t5.cdone", bus.g_cpu_cycle_done, 1);
      chk("t5.data",  bus.h_rd_data, 32'hC1);
      cyc(0, 0, 1, 0, 1);
      chk("t5.ddone", bus.g_cpu_data_done, 1);
      chk("t5.busy",  bus.busy, 0);

      // read latch follows accepted beats and holds through idle
      cyc(1, 1, 1, 0, 0);
      cyc(0, 0, 0, 32'h11, 0);
      cyc(0, 0, 0, 32'h22, 0);
`ifdef CPU_RD_LATCH_EN
      chk("t6.latch", bus.g_latch_data, 32'h22);
`else
      chk("t6.latch", bus.g_latch_data, 32'h0);
`endif
      cyc(0, 0, 1, 0, 1);
      cyc(0, 0, 1, 0, 1);
      cyc(0, 0, 0, 32'h99, 0);   // dropped beat in idle must not touch the latch
      cyc(0, 0, 1, 0, 0);
`ifdef CPU_RD_LATCH_EN
      chk("t6.latch_hold", bus.g_latch_data, 32'h22);
`else
      chk("t6.latch_hold", bus.g_latch_data, 32'h0);
`endif

      // random traffic against the model, re-armed by periodic resets
      for (int n = 0; n < 3000; n++) begin
         bit          st, rn, ack;
         logic [1:0]  ln;
         logic [31:0] d;
         if (n % 250 == 0) do_reset("rnd_rst");
         st  = ($urandom % 5) == 0;
         ln  = 2'($urandom);
         rn  = (m_phase == 1) ? 1'($urandom) : (($urandom % 10) != 0);
         d   = $urandom;
         ack = 1'($urandom);
         cyc(st, ln, rn, d, ack);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
